// File: rtl/corelet_ctrl.sv
// corelet_ctrl: control sequencer for one weight-stationary corelet tile.
// Loads `row` weights xmem -> L0 -> MAC array, waits `col` cycles for
// propagation, streams `n_act` activations through L0 in execute mode, then
// drains every psum vector from the OFIFO into pmem.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int xaddr_w = 11,
  parameter int paddr_w = 11,
  parameter int cnt_w   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [xaddr_w-1:0] w_base,
  input  logic [xaddr_w-1:0] a_base,
  input  logic [paddr_w-1:0] p_base,
  input  logic [cnt_w-1:0]   n_act,
  input  logic               ofifo_valid,
  output logic               xmem_cen,
  output logic               xmem_wen,
  output logic [xaddr_w-1:0] xmem_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic [1:0]         inst,
  output logic               ofifo_rd,
  output logic               pmem_cen,
  output logic               pmem_wen,
  output logic [paddr_w-1:0] pmem_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLD_L0,
    S_KLD_ARR,
    S_KWAIT,
    S_ACT_L0,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [cnt_w-1:0] ROW_C  = cnt_w'(row);
  localparam logic [cnt_w-1:0] ROW_M1 = cnt_w'(row - 1);
  localparam logic [cnt_w-1:0] COL_M1 = cnt_w'(col - 1);

  state_t               r_state, w_state_nxt;
  logic [cnt_w-1:0]     r_cnt, w_cnt_nxt;
  logic [cnt_w-1:0]     r_pops, w_pops_nxt;
  logic [xaddr_w-1:0]   r_w_base, r_a_base;
  logic [paddr_w-1:0]   r_p_base;
  logic [cnt_w-1:0]     r_n_act;

  logic                 w_pop;
  logic [xaddr_w-1:0]   w_xbase;
  logic                 w_xmem_cen_nxt;
  logic [xaddr_w-1:0]   w_xmem_addr_nxt;
  logic                 w_l0_wr_nxt;
  logic                 w_l0_rd_nxt;
  logic [1:0]           w_inst_nxt;
  logic                 w_pmem_cen_nxt;
  logic [paddr_w-1:0]   w_pmem_addr_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  // This block never writes xmem.
  assign xmem_wen = 1'b1;

  // OFIFO pop is the only combinational output: it must react to ofifo_valid
  // in the same cycle so stalls cost no extra latency.
  assign w_pop    = (r_state == S_DRAIN) && ofifo_valid && (r_pops < r_n_act);
  assign ofifo_rd = w_pop;

  // State register, per-state cycle counter, pop counter and latched tile parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pops   <= '0;
      r_w_base <= '0;
      r_a_base <= '0;
      r_p_base <= '0;
      r_n_act  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pops  <= w_pops_nxt;
      if (r_state == S_IDLE && start) begin
        r_w_base <= w_base;
        r_a_base <= a_base;
        r_p_base <= p_base;
        r_n_act  <= n_act;
      end
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pops_nxt  = r_pops;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_KLD_L0;
          w_cnt_nxt   = '0;
          w_pops_nxt  = '0;
        end
      end
      S_KLD_L0: begin
        if (r_cnt == ROW_C) begin
          w_state_nxt = S_KLD_ARR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_KLD_ARR: begin
        if (r_cnt == ROW_M1) begin
          w_state_nxt = S_KWAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_KWAIT: begin
        if (r_cnt == COL_M1) begin
          w_state_nxt = (r_n_act == '0) ? S_DONE : S_ACT_L0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ACT_L0: begin
        if (r_cnt == r_n_act) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_EXEC: begin
        if (r_cnt == r_n_act - 1'b1) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
          w_pops_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_pop) begin
          w_pops_nxt = r_pops + 1'b1;
        end
        // pops reaching n_act means this cycle carries the final pmem write
        if (r_pops == r_n_act) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from next state/counter so
  // that every strobe except ofifo_rd comes straight from a flop.
  always_comb begin
    w_xbase          = (r_state == S_IDLE) ? w_base : r_w_base;
    w_xmem_cen_nxt   = 1'b1;
    w_xmem_addr_nxt  = xmem_addr;
    w_l0_wr_nxt      = 1'b0;
    w_l0_rd_nxt      = 1'b0;
    w_inst_nxt       = 2'b00;
    w_pmem_cen_nxt   = 1'b1;
    w_pmem_addr_nxt  = pmem_addr;
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_done_nxt       = 1'b0;
    case (w_state_nxt)
      S_KLD_L0: begin
        if (w_cnt_nxt != ROW_C) begin
          w_xmem_cen_nxt  = 1'b0;
          w_xmem_addr_nxt = w_xbase + xaddr_w'(w_cnt_nxt);
        end
        w_l0_wr_nxt = (w_cnt_nxt != '0);
      end
      S_KLD_ARR: begin
        w_l0_rd_nxt = 1'b1;
        w_inst_nxt  = 2'b01;
      end
      S_ACT_L0: begin
        if (w_cnt_nxt != r_n_act) begin
          w_xmem_cen_nxt  = 1'b0;
          w_xmem_addr_nxt = r_a_base + xaddr_w'(w_cnt_nxt);
        end
        w_l0_wr_nxt = (w_cnt_nxt != '0);
      end
      S_EXEC: begin
        w_l0_rd_nxt = 1'b1;
        w_inst_nxt  = 2'b10;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
      end
    endcase
    // each pop is followed one cycle later by its pmem write
    if (w_pop) begin
      w_pmem_cen_nxt  = 1'b0;
      w_pmem_addr_nxt = r_p_base + paddr_w'(r_pops);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      l0_wr     <= 1'b0;
      l0_rd     <= 1'b0;
      inst      <= 2'b00;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      xmem_cen  <= w_xmem_cen_nxt;
      xmem_addr <= w_xmem_addr_nxt;
      l0_wr     <= w_l0_wr_nxt;
      l0_rd     <= w_l0_rd_nxt;
      inst      <= w_inst_nxt;
      pmem_cen  <= w_pmem_cen_nxt;
      pmem_wen  <= w_pmem_cen_nxt;
      pmem_addr <= w_pmem_addr_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: stimulus pushes expected xmem reads,
// pmem writes and per-tile totals into queues; a negedge monitor pops and
// compares whenever the DUT presents a read, a write or a done pulse.
module tb_corelet_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int XW  = 11;
  localparam int PW  = 11;
  localparam int CW  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] w_base, a_base;
  logic [PW-1:0] p_base;
  logic [CW-1:0] n_act;
  logic          ofifo_valid;
  logic          xmem_cen, xmem_wen, l0_wr, l0_rd, ofifo_rd;
  logic          pmem_cen, pmem_wen, busy, done;
  logic [XW-1:0] xmem_addr;
  logic [PW-1:0] pmem_addr;
  logic [1:0]    inst;

  corelet_ctrl #(.row(ROW), .col(COL), .xaddr_w(XW), .paddr_w(PW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .a_base(a_base), .p_base(p_base), .n_act(n_act),
    .ofifo_valid(ofifo_valid),
    .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .inst(inst), .ofifo_rd(ofifo_rd),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy;
    int xreads;
    int l0wr;
    int l0rd;
    int i01;
    int i10;
    int pops;
    int writes;
  } tile_exp_t;

  int        xq[$];
  int        pq[$];
  tile_exp_t dq[$];
  int        tests = 0;
  int        fails = 0;
  bit        tile_done;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xmem_cen"}, xmem_cen, 1);
    check({tag, "_xmem_wen"}, xmem_wen, 1);
    check({tag, "_xmem_addr"}, xmem_addr, 0);
    check({tag, "_pmem_cen"}, pmem_cen, 1);
    check({tag, "_pmem_wen"}, pmem_wen, 1);
    check({tag, "_pmem_addr"}, pmem_addr, 0);
    check({tag, "_l0_wr"}, l0_wr, 0);
    check({tag, "_l0_rd"}, l0_rd, 0);
    check({tag, "_inst"}, inst, 0);
    check({tag, "_ofifo_rd"}, ofifo_rd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Monitor: per-cycle protocol rules plus queue-driven address/total checks.
  int m_busy, m_xr, m_l0wr, m_l0rd, m_i01, m_i10, m_pops, m_wr;
  bit prev_xrd, prev_ofrd, prev_done;
  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_xr = 0; m_l0wr = 0; m_l0rd = 0;
      m_i01 = 0; m_i10 = 0; m_pops = 0; m_wr = 0;
      prev_xrd = 0; prev_ofrd = 0; prev_done = 0;
    end else begin
      check("xmem_wen_high", xmem_wen, 1);
      if (l0_wr || prev_xrd) check("l0_wr_lags_read", l0_wr, prev_xrd);
      if (l0_rd || inst != 2'b00) begin
        check("l0_rd_with_inst", l0_rd, (inst != 2'b00));
        check("inst_not_both", (inst == 2'b11), 0);
      end
      if (ofifo_rd) check("ofifo_rd_needs_valid", ofifo_valid, 1);
      if (!pmem_cen || prev_ofrd) begin
        check("pmem_write_after_pop", !pmem_cen, prev_ofrd);
        check("pmem_wen_eq_cen", pmem_wen, pmem_cen);
      end
      if (!busy) check("idle_strobes", {xmem_cen, pmem_cen, l0_wr, l0_rd, inst, ofifo_rd}, 7'b1100000);
      if (prev_done) check("busy_drops_after_done", busy, 0);
      if (!xmem_cen) begin
        check("xmem_read_expected", (xq.size() > 0), 1);
        if (xq.size() > 0) check("xmem_addr", xmem_addr, xq.pop_front());
        m_xr++;
      end
      if (!pmem_cen) begin
        check("pmem_write_expected", (pq.size() > 0), 1);
        if (pq.size() > 0) check("pmem_addr", pmem_addr, pq.pop_front());
        m_wr++;
      end
      if (busy) m_busy++;
      if (l0_wr) m_l0wr++;
      if (l0_rd) m_l0rd++;
      if (inst == 2'b01) m_i01++;
      if (inst == 2'b10) m_i10++;
      if (ofifo_rd) m_pops++;
      if (done) begin
        check("done_expected", (dq.size() > 0), 1);
        if (dq.size() > 0) begin
          tile_exp_t e;
          e = dq.pop_front();
          check("busy_cycles", m_busy, e.busy);
          check("xmem_reads", m_xr, e.xreads);
          check("l0_wr_count", m_l0wr, e.l0wr);
          check("l0_rd_count", m_l0rd, e.l0rd);
          check("inst01_count", m_i01, e.i01);
          check("inst10_count", m_i10, e.i10);
          check("ofifo_pops", m_pops, e.pops);
          check("pmem_writes", m_wr, e.writes);
        end
        m_busy = 0; m_xr = 0; m_l0wr = 0; m_l0rd = 0;
        m_i01 = 0; m_i10 = 0; m_pops = 0; m_wr = 0;
        tile_done = 1;
      end
      prev_xrd  = !xmem_cen;
      prev_ofrd = ofifo_rd;
      prev_done = done;
    end
  end

  // vmode: 0 = ofifo_valid held 1 in DRAIN, 1 = random, 2 = pattern 1,0,0,1,0,1 then 1.
  // abort_at: tile cycle at which reset is pulsed (-1 = none).
  // start_at: tile cycle for a spurious start (-1 = none); start_in_done adds one in the DONE cycle.
  task automatic run_tile(input int wb, input int ab, input int pb, input int n,
                          input int vmode, input int abort_at, input int start_at,
                          input bit start_in_done);
    int pat[6];
    int drain_start, ones, busy_exp, c, d;
    bit v;
    tile_exp_t e;
    pat = '{1, 0, 0, 1, 0, 1};
    for (int k = 0; k < ROW; k++) xq.push_back((wb + k) % (1 << XW));
    for (int k = 0; k < n; k++)   xq.push_back((ab + k) % (1 << XW));
    for (int k = 0; k < n; k++)   pq.push_back((pb + k) % (1 << PW));
    drain_start = (ROW + 1) + ROW + COL + (n + 1) + n;
    ones = 0;
    busy_exp = -1;
    e.xreads = ROW + n; e.l0wr = ROW + n; e.l0rd = ROW + n;
    e.i01 = ROW; e.i10 = n; e.pops = n; e.writes = n;
    if (n == 0) begin
      busy_exp = (ROW + 1) + ROW + COL + 1;
      e.busy = busy_exp;
      dq.push_back(e);
    end
    tile_done = 0;
    w_base = XW'(wb); a_base = XW'(ab); p_base = PW'(pb); n_act = CW'(n);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    // parameters changed after acceptance must not matter
    w_base = XW'($urandom); a_base = XW'($urandom); p_base = PW'($urandom); n_act = CW'($urandom);
    c = 0;
    while (!tile_done && c < 3000) begin
      start = (c == start_at) || (start_in_done && busy_exp > 0 && c == busy_exp - 1);
      if (n == 0 || c < drain_start) begin
        ofifo_valid = 1'($urandom);
      end else begin
        d = c - drain_start;
        case (vmode)
          0:       v = 1'b1;
          1:       v = 1'($urandom);
          default: v = (d < 6) ? (pat[d] != 0) : 1'b1;
        endcase
        ofifo_valid = v;
        if (v && ones < n) begin
          ones++;
          if (ones == n) begin
            busy_exp = drain_start + d + 3;
            e.busy = busy_exp;
            dq.push_back(e);
          end
        end
      end
      if (c == abort_at) begin
        reset = 1;
        #2;
        check_reset_outputs("midtile_reset");
        xq.delete(); pq.delete(); dq.delete();
        start = 0;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 0;
    check("tile_completed", tile_done, 1);
    if (!tile_done) begin
      reset = 1;
      @(posedge clk); #1;
      xq.delete(); pq.delete(); dq.delete();
      reset = 0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("no_restart", busy, 0);
  endtask

  initial begin
    reset = 1; start = 0; ofifo_valid = 0;
    w_base = '0; a_base = '0; p_base = '0; n_act = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 0;
    @(posedge clk); #1;

    run_tile(0, 8, 0, 4, 0, -1, -1, 0);
    run_tile(5, 100, 7, 0, 0, -1, -1, 0);
    run_tile(16, 40, 300, 3, 2, -1, -1, 0);
    run_tile(0, 8, 0, 5, 0, (ROW + 1) + ROW + COL + 6 + 2, -1, 0);
    run_tile(33, 200, 12, 5, 0, -1, -1, 0);
    run_tile(1, 2, 3, 2, 0, -1, (ROW + 1) + ROW + 2, 1);
    run_tile(0, 2046, 2045, 4, 1, -1, -1, 0);
    for (int i = 0; i < 8; i++)
      run_tile(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 12)), 1, -1, -1, 0);

    check("leftover_xmem_reads", xq.size(), 0);
    check("leftover_pmem_writes", pq.size(), 0);
    check("leftover_done", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
